fpu_vec_driver: RTL and testbench
=================================

Name: fpu_vec_driver

Overview:
Hardware stimulus/checker engine that acts as the initiator of the combinational bfloat16 fpu interface (op one-hot, two 16-bit operands, 16-bit result, overflow flag). On start it streams N_VEC operand pairs and golden results from synchronous-read vector memories, drives the fpu, compares each result exactly, and reports an error count, overflow count and first-failure record. It is the on-chip self-test counterpart of the fpu simulation bench and sits beside the fpu in the arithmetic test harness.

Parameters:
N_VEC, 10, number of vectors per run (1..2**AW)
AW, 4, vector memory address width

Ports:
clk  in  1  clock
rst  in  1  reset
start_i  in  1  start request; sampled only in IDLE
op_i  in  4  one-hot op (0001 add, 0010 sub, 0100 mul, 1000 div); latched at start
vec_addr_o  out  AW  vector memory address
vec_rd_o  out  1  vector memory read enable
in1_mem_i  in  16  operand A read data (valid cycle after address is sampled)
in2_mem_i  in  16  operand B read data
gold_i  in  16  golden result read data (same timing)
fpu_op_o  out  4  op to fpu
fpu_in1_o  out  16  operand A to fpu
fpu_in2_o  out  16  operand B to fpu
fpu_out_i  in  16  fpu result (combinational from fpu_*_o)
fpu_overflow_i  in  1  fpu overflow flag
busy_o  out  1  run in progress
done_o  out  1  one-cycle completion pulse
pass_o  out  1  last run had zero mismatches; held until next start
err_cnt_o  out  16  mismatch count, saturating at 16'hFFFF
ovf_cnt_o  out  16  overflow-flag count, saturating
first_err_idx_o  out  AW  index of first mismatching vector
first_err_val_o  out  16  fpu result at first mismatch

Behaviour:
- Reset rst, synchronous, active-high; clock clk. Reset forces IDLE; all outputs, counters, pipeline valids and registers to 0. Reset mid-run aborts: no done_o pulse, pass_o=0.
- States: IDLE -> (start_i) ISSUE -> (last address issued) DRAIN -> (last compare) DONE -> IDLE (one cycle). start_i outside IDLE ignored.
- At start edge E0: latch op_i into fpu_op_o; clear err_cnt, ovf_cnt, first_err_*, pass_o; vec_addr_o=0, vec_rd_o=1, busy_o=1.
- ISSUE: vec_addr_o increments by 1 each edge, 0..N_VEC-1; vec_rd_o=1 only while issuing a valid address; no wrap beyond N_VEC-1.
- Pipeline: address k presented after E(k); memory data present after E(k+1); captured into fpu_in1_o/fpu_in2_o/gold register at E(k+2) with valid bit; compare of fpu_out_i vs gold register at E(k+3). Throughput one vector/cycle.
- Compare: bitwise exact 16-bit equality (no NaN/±0 equivalence). Mismatch increments err_cnt (saturating); first mismatch only records index and fpu_out_i. fpu_overflow_i=1 on a valid compare cycle increments ovf_cnt regardless of match.
- Last compare (k=N_VEC-1) at E(N_VEC+2): done_o=1 during following cycle, busy_o=0 same cycle, pass_o=(final err_cnt==0). done_o deasserts next edge.
- fpu_in*_o hold last vector after run; fpu_op_o holds latched op until next start.
- Non-one-hot op_i is latched and driven unchanged; checker still compares.
- start_i held high continuously: a new run begins the edge after DONE returns to IDLE.

Test Plan:
- ADD, N_VEC=2, vectors (3F80,4000,gold 4040),(4000,4000,gold 4080), fpu model correct -> done_o pulse exactly 4 cycles after start edge, err_cnt_o=0, pass_o=1, first_err_idx_o=0.
- Same vectors with gold[1]=4081 -> err_cnt_o=1, first_err_idx_o=1, first_err_val_o=4080, pass_o=0.
- MUL, N_VEC=10, vectors 3 and 7 mismatching, vector 5 with fpu_overflow_i=1 -> err_cnt_o=2, first_err_idx_o=3, ovf_cnt_o=1; vec_addr_o sequence 0..9 with vec_rd_o high exactly 10 cycles.
- start_i pulsed again while busy_o=1 -> ignored; counters and vec_addr_o sequence unaffected; single done_o pulse.
- rst asserted at 3rd ISSUE cycle -> next cycle all outputs 0, state IDLE, no done_o; subsequent start runs full 10 vectors cleanly.
- start_i held high with op_i=1000 -> back-to-back runs, each clearing err_cnt_o at start, fpu_op_o=1000, done_o pulse every N_VEC+3 cycles.

Source files
------------

// File: rtl/fpu_vec_driver.sv
// rtl/fpu_vec_driver.sv - bfloat16 fpu self-test driver: streams vectors, compares results, counts errors/overflows
module fpu_vec_driver #(
  parameter int N_VEC = 10,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [3:0]    op_i,
  output logic [AW-1:0] vec_addr_o,
  output logic          vec_rd_o,
  input  logic [15:0]   in1_mem_i,
  input  logic [15:0]   in2_mem_i,
  input  logic [15:0]   gold_i,
  output logic [3:0]    fpu_op_o,
  output logic [15:0]   fpu_in1_o,
  output logic [15:0]   fpu_in2_o,
  input  logic [15:0]   fpu_out_i,
  input  logic          fpu_overflow_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [15:0]   err_cnt_o,
  output logic [15:0]   ovf_cnt_o,
  output logic [AW-1:0] first_err_idx_o,
  output logic [15:0]   first_err_val_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_VEC - 1);

  // DRAIN covers the capture of the last vector; DONE covers its compare,
  // so the run leaves DONE on the same edge that performs the last compare.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic [3:0]    op_q, op_d;
  logic          mem_vld_q, mem_vld_d;   // memory read data valid this cycle
  logic [15:0]   in1_q, in1_d;
  logic [15:0]   in2_q, in2_d;
  logic [15:0]   gold_q, gold_d;
  logic          cmp_vld_q, cmp_vld_d;   // fpu inputs/gold valid, compare this cycle
  logic [AW-1:0] cmp_idx_q, cmp_idx_d;
  logic [15:0]   err_q, err_d;
  logic [15:0]   ovf_q, ovf_d;
  logic [AW-1:0] fidx_q, fidx_d;
  logic [15:0]   fval_q, fval_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;

  // Next-state: FSM sequencing, address issue, operand capture and compare
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    op_d      = op_q;
    mem_vld_d = rd_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    gold_d    = gold_q;
    cmp_vld_d = mem_vld_q;
    cmp_idx_d = cmp_idx_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    fidx_d    = fidx_q;
    fval_d    = fval_q;
    pass_d    = pass_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_ISSUE;
          addr_d    = '0;
          rd_d      = 1'b1;
          op_d      = op_i;
          cmp_idx_d = '0;
          err_d     = '0;
          ovf_d     = '0;
          fidx_d    = '0;
          fval_d    = '0;
          pass_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          rd_d    = 1'b0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (mem_vld_q) begin
      in1_d  = in1_mem_i;
      in2_d  = in2_mem_i;
      gold_d = gold_i;
    end

    if (cmp_vld_q) begin
      cmp_idx_d = cmp_idx_q + AW'(1);
      if (fpu_out_i != gold_q) begin
        if (err_q == 16'h0000) begin
          fidx_d = cmp_idx_q;
          fval_d = fpu_out_i;
        end
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end
      if (fpu_overflow_i && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
    end

    // pass uses the count including the final compare happening on this edge
    if (state_q == S_DONE) begin
      done_d = 1'b1;
      pass_d = (err_d == 16'h0000);
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      op_q      <= '0;
      mem_vld_q <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      gold_q    <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      err_q     <= '0;
      ovf_q     <= '0;
      fidx_q    <= '0;
      fval_q    <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      op_q      <= op_d;
      mem_vld_q <= mem_vld_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      gold_q    <= gold_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      fidx_q    <= fidx_d;
      fval_q    <= fval_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
    end
  end

  assign vec_addr_o      = addr_q;
  assign vec_rd_o        = rd_q;
  assign fpu_op_o        = op_q;
  assign fpu_in1_o       = in1_q;
  assign fpu_in2_o       = in2_q;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_cnt_o       = err_q;
  assign ovf_cnt_o       = ovf_q;
  assign first_err_idx_o = fidx_q;
  assign first_err_val_o = fval_q;

endmodule

// File: tb/tb_fpu_vec_driver.sv
// tb/tb_fpu_vec_driver.sv - directed self-checking bench for fpu_vec_driver
module tb_fpu_vec_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st  = 1'b0;
  logic sel = 1'b0;        // 0: two-vector instance, 1: ten-vector instance
  logic [3:0] op = 4'b0001;

  always #5 clk = ~clk;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic [15:0] mem_g [16];
  logic [15:0] res_tab [16];
  logic        ovf_tab [16];

  logic st2, st10;
  assign st2  = st & ~sel;
  assign st10 = st & sel;

  logic [3:0]  addr2, addr10, fidx2, fidx10;
  logic        rd2, rd10, fov2, fov10, busy2, busy10, done2, done10, pass2, pass10;
  logic [3:0]  fop2, fop10;
  logic [15:0] a2, b2, g2, a10, b10, g10;
  logic [15:0] fi1_2, fi2_2, fo2, fi1_10, fi2_10, fo10;
  logic [15:0] err2, err10, ovf2, ovf10, fval2, fval10;

  fpu_vec_driver #(.N_VEC(2), .AW(4)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(st2), .op_i(op),
    .vec_addr_o(addr2), .vec_rd_o(rd2),
    .in1_mem_i(a2), .in2_mem_i(b2), .gold_i(g2),
    .fpu_op_o(fop2), .fpu_in1_o(fi1_2), .fpu_in2_o(fi2_2),
    .fpu_out_i(fo2), .fpu_overflow_i(fov2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_cnt_o(err2), .ovf_cnt_o(ovf2),
    .first_err_idx_o(fidx2), .first_err_val_o(fval2)
  );

  fpu_vec_driver #(.N_VEC(10), .AW(4)) u_dut10 (
    .clk(clk), .rst(rst), .start_i(st10), .op_i(op),
    .vec_addr_o(addr10), .vec_rd_o(rd10),
    .in1_mem_i(a10), .in2_mem_i(b10), .gold_i(g10),
    .fpu_op_o(fop10), .fpu_in1_o(fi1_10), .fpu_in2_o(fi2_10),
    .fpu_out_i(fo10), .fpu_overflow_i(fov10),
    .busy_o(busy10), .done_o(done10), .pass_o(pass10),
    .err_cnt_o(err10), .ovf_cnt_o(ovf10),
    .first_err_idx_o(fidx10), .first_err_val_o(fval10)
  );

  // synchronous-read vector memories
  always @(posedge clk) begin
    if (rd2)  begin a2  <= mem_a[addr2];  b2  <= mem_b[addr2];  g2  <= mem_g[addr2];  end
    if (rd10) begin a10 <= mem_a[addr10]; b10 <= mem_b[addr10]; g10 <= mem_g[addr10]; end
  end

  // table-driven fpu: result chosen by operand pair
  always_comb begin
    fo2 = 16'h0; fov2 = 1'b0;
    for (int i = 0; i < 16; i++)
      if (mem_a[i] == fi1_2 && mem_b[i] == fi2_2) begin fo2 = res_tab[i]; fov2 = ovf_tab[i]; end
  end
  always_comb begin
    fo10 = 16'h0; fov10 = 1'b0;
    for (int i = 0; i < 16; i++)
      if (mem_a[i] == fi1_10 && mem_b[i] == fi2_10) begin fo10 = res_tab[i]; fov10 = ovf_tab[i]; end
  end

  logic done_s, busy_s, rd_s;
  logic [3:0] addr_s;
  assign done_s = sel ? done10 : done2;
  assign busy_s = sel ? busy10 : busy2;
  assign rd_s   = sel ? rd10   : rd2;
  assign addr_s = sel ? addr10 : addr2;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int addr_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // address/read-enable monitor
  always @(negedge clk) begin
    if (rd_s) begin
      if (int'(addr_s) != rd_cnt) addr_bad = addr_bad + 1;
      rd_cnt = rd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic load_default();
    for (int i = 0; i < 16; i++) begin
      mem_a[i]   = 16'h4000 + 16'(i);
      mem_b[i]   = 16'h3F00 + 16'(i);
      mem_g[i]   = 16'h1000 + 16'(i);
      res_tab[i] = 16'h1000 + 16'(i);
      ovf_tab[i] = 1'b0;
    end
  endtask

  // one start pulse, then ncyc cycles; optional extra start pulses at p1/p2
  task automatic run(input int ncyc, input int p1, input int p2,
                     output int fdone, output int ndone, output logic bz);
    fdone = -1; ndone = 0; bz = 1'b1;
    rd_cnt = 0; addr_bad = 0;
    @(negedge clk); st = 1'b1;
    @(posedge clk); #1 st = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1 st = (c == p1) || (c == p2);
      @(negedge clk);
      if (done_s) begin
        ndone++;
        if (fdone < 0) begin fdone = c; bz = busy_s; end
      end
    end
    st = 1'b0;
  endtask

  int fd, nd, nd2;
  logic bz;
  int dt [4];
  int de [4];

  initial begin
    load_default();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_busy", busy10, 0);
    chk("rst_done", done10, 0);
    chk("rst_pass", pass10, 0);
    chk("rst_err", err10, 0);
    chk("rst_ovf", ovf10, 0);
    chk("rst_rd_addr", {rd10, addr10}, 0);
    chk("rst_fpu", {fop10, fi1_10}, 0);

    // two vectors ADD, correct fpu
    mem_a[0] = 16'h3F80; mem_b[0] = 16'h4000; mem_g[0] = 16'h4040; res_tab[0] = 16'h4040;
    mem_a[1] = 16'h4000; mem_b[1] = 16'h4000; mem_g[1] = 16'h4080; res_tab[1] = 16'h4080;
    sel = 1'b0; op = 4'b0001;
    run(10, -1, -1, fd, nd, bz);
    chk("add_done_lat", fd, 4);
    chk("add_ndone", nd, 1);
    chk("add_busy_at_done", bz, 0);
    chk("add_err", err2, 0);
    chk("add_pass", pass2, 1);
    chk("add_fidx", fidx2, 0);
    chk("add_rdcnt", rd_cnt, 2);
    chk("add_op", fop2, 4'b0001);

    // gold[1] wrong
    mem_g[1] = 16'h4081;
    run(10, -1, -1, fd, nd, bz);
    chk("g1_err", err2, 1);
    chk("g1_fidx", fidx2, 1);
    chk("g1_fval", fval2, 16'h4080);
    chk("g1_pass", pass2, 0);

    // ten vectors MUL, vectors 3,7 bad, vector 5 overflow
    load_default();
    res_tab[3] = 16'h1103; res_tab[7] = 16'h1107; ovf_tab[5] = 1'b1;
    sel = 1'b1; op = 4'b0100;
    run(20, -1, -1, fd, nd, bz);
    chk("mul_done_lat", fd, 12);
    chk("mul_ndone", nd, 1);
    chk("mul_busy_at_done", bz, 0);
    chk("mul_err", err10, 2);
    chk("mul_fidx", fidx10, 3);
    chk("mul_fval", fval10, 16'h1103);
    chk("mul_ovf", ovf10, 1);
    chk("mul_pass", pass10, 0);
    chk("mul_rdcnt", rd_cnt, 10);
    chk("mul_addr_seq", addr_bad, 0);
    chk("mul_op", fop10, 4'b0100);
    chk("mul_hold_in", {fi1_10, fi2_10}, {16'h4009, 16'h3F09});

    // restart while busy is ignored
    run(20, 3, 7, fd, nd, bz);
    chk("busy_start_ndone", nd, 1);
    chk("busy_start_lat", fd, 12);
    chk("busy_start_err", err10, 2);
    chk("busy_start_ovf", ovf10, 1);
    chk("busy_start_rdcnt", rd_cnt, 10);
    chk("busy_start_addr", addr_bad, 0);

    // reset during third ISSUE cycle
    @(negedge clk); st = 1'b1;
    @(posedge clk); #1 st = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy10, 0);
    chk("abort_done_pass", {done10, pass10}, 0);
    chk("abort_cnts", {err10, ovf10}, 0);
    chk("abort_first", {fidx10, fval10}, 0);
    chk("abort_rd_addr", {rd10, addr10}, 0);
    chk("abort_fpu", {fop10, fi1_10, 12'h000}, 0);
    rst = 1'b0;
    nd2 = 0;
    repeat (15) begin
      @(negedge clk);
      if (done10) nd2++;
    end
    chk("abort_no_done", nd2, 0);

    load_default();
    run(20, -1, -1, fd, nd, bz);
    chk("clean_lat", fd, 12);
    chk("clean_err", err10, 0);
    chk("clean_pass", pass10, 1);
    chk("clean_ovf", ovf10, 0);
    chk("clean_rdcnt", rd_cnt, 10);

    // start held high: back-to-back runs
    res_tab[3] = 16'h1103;
    op = 4'b1000;
    nd = 0;
    @(negedge clk); st = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done10 && nd < 4) begin dt[nd] = cyc; de[nd] = int'(err10); nd++; end
    end
    st = 1'b0;
    chk("hold_ndone", (nd >= 3), 1);
    if (nd >= 3) begin
      chk("hold_period1", dt[1] - dt[0], 13);
      chk("hold_period2", dt[2] - dt[1], 13);
      chk("hold_err0", de[0], 1);
      chk("hold_err1", de[1], 1);
      chk("hold_err2", de[2], 1);
    end
    chk("hold_op", fop10, 4'b1000);
    repeat (20) @(negedge clk);
    chk("hold_idle", busy10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
